// File: rtl/btn_repeat_sched_pkg.sv
// rtl/btn_repeat_sched_pkg.sv - shared states, directions and default timing for the repeat scheduler
package btn_repeat_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_SLOW = 3'd2,
        ST_FAST = 3'd3,
        ST_LOCK = 3'd4
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int C_HOLD_MS    = 500;
    localparam int C_SLOW_MS    = 200;
    localparam int C_FAST_MS    = 50;
    localparam int C_FAST_AFTER = 8;
    localparam int C_CNT_W      = 10;

endpackage

// File: rtl/tick_interval_cnt.sv
// rtl/tick_interval_cnt.sv - counts 1 ms ticks and strobes when the selected period elapses
module tick_interval_cnt
    import btn_repeat_sched_pkg::*;
#(
    parameter int P_CNT_W = C_CNT_W
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iClear,
    input  logic               iTick,
    input  logic [P_CNT_W-1:0] iPeriod,
    output logic               oExpire
);

    localparam logic [P_CNT_W-1:0] C_ONE = P_CNT_W'(1);

    logic [P_CNT_W-1:0] rCnt;

    assign oExpire = iTick && (rCnt == (iPeriod - C_ONE));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rCnt <= '0;
        end else if (iClear || oExpire) begin
            rCnt <= '0;
        end else if (iTick) begin
            rCnt <= rCnt + C_ONE;
        end
    end

endmodule

// File: rtl/btn_repeat_sched.sv
// rtl/btn_repeat_sched.sv - turns held U/D buttons into accelerating one-cycle step pulses
module btn_repeat_sched
    import btn_repeat_sched_pkg::*;
#(
    parameter int P_HOLD_MS    = C_HOLD_MS,
    parameter int P_SLOW_MS    = C_SLOW_MS,
    parameter int P_FAST_MS    = C_FAST_MS,
    parameter int P_FAST_AFTER = C_FAST_AFTER,
    parameter int P_CNT_W      = C_CNT_W
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iTick_1ms,
    input  logic iEn,
    input  logic iBtn_U,
    input  logic iBtn_D,
    output logic oUp,
    output logic oDown,
    output logic oRepeat,
    output logic oBusy
);

    localparam int                 C_REP_W   = $clog2(P_FAST_AFTER + 1);
    localparam logic [C_REP_W-1:0] C_REP_MAX = C_REP_W'(P_FAST_AFTER);
    localparam logic [C_REP_W-1:0] C_REP_ONE = C_REP_W'(1);

    state_t               rState, stNext;
    logic                 rDir, dirNext;
    logic [C_REP_W-1:0]   rRep, repNext;
    logic                 rBlock;
    logic                 upNext, dnNext;
    logic                 activeBtn, oppBtn;
    logic                 cntClear, expire;
    logic [P_CNT_W-1:0]   period;

    always_comb begin
        case (rState)
            ST_HOLD: period = P_CNT_W'(P_HOLD_MS);
            ST_SLOW: period = P_CNT_W'(P_SLOW_MS);
            default: period = P_CNT_W'(P_FAST_MS);
        endcase
    end

    tick_interval_cnt #(
        .P_CNT_W (P_CNT_W)
    ) u_interval (
        .iClk    (iClk),
        .iRst    (iRst),
        .iClear  (cntClear),
        .iTick   (iTick_1ms),
        .iPeriod (period),
        .oExpire (expire)
    );

    always_comb begin
        stNext    = rState;
        dirNext   = rDir;
        repNext   = rRep;
        upNext    = 1'b0;
        dnNext    = 1'b0;
        activeBtn = (rDir == DIR_UP) ? iBtn_U : iBtn_D;
        oppBtn    = (rDir == DIR_UP) ? iBtn_D : iBtn_U;
        if (!iEn) begin
            stNext = ST_IDLE;
        end else begin
            case (rState)
                ST_IDLE: begin
                    // rBlock keeps a button held across an enable drop from re-triggering
                    if (!rBlock) begin
                        if (iBtn_U ^ iBtn_D) begin
                            stNext  = ST_HOLD;
                            dirNext = iBtn_U ? DIR_UP : DIR_DN;
                            repNext = '0;
                            upNext  = iBtn_U;
                            dnNext  = iBtn_D;
                        end else if (iBtn_U && iBtn_D) begin
                            stNext = ST_LOCK;
                        end
                    end
                end
                ST_HOLD, ST_SLOW, ST_FAST: begin
                    if (!activeBtn) begin
                        stNext = ST_IDLE;
                    end else if (oppBtn) begin
                        stNext = ST_LOCK;
                    end else if (expire) begin
                        upNext = (rDir == DIR_UP);
                        dnNext = (rDir == DIR_DN);
                        if (rState == ST_HOLD) begin
                            repNext = C_REP_ONE;
                            stNext  = ST_SLOW;
                        end else if (rState == ST_SLOW) begin
                            repNext = (rRep == C_REP_MAX) ? rRep : rRep + C_REP_ONE;
                            if (repNext >= C_REP_MAX) begin
                                stNext = ST_FAST;
                            end
                        end
                    end
                end
                ST_LOCK: begin
                    if (!iBtn_U && !iBtn_D) begin
                        stNext = ST_IDLE;
                    end
                end
                default: stNext = ST_IDLE;
            endcase
        end
        cntClear = (stNext != rState) || (rState == ST_IDLE) || (rState == ST_LOCK);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rState  <= ST_IDLE;
            rDir    <= DIR_UP;
            rRep    <= '0;
            rBlock  <= 1'b0;
            oUp     <= 1'b0;
            oDown   <= 1'b0;
            oRepeat <= 1'b0;
            oBusy   <= 1'b0;
        end else begin
            rState  <= stNext;
            rDir    <= dirNext;
            rRep    <= repNext;
            oUp     <= upNext;
            oDown   <= dnNext;
            oRepeat <= (stNext == ST_HOLD) || (stNext == ST_SLOW) || (stNext == ST_FAST);
            oBusy   <= (stNext != ST_IDLE);
            if (!iEn && (iBtn_U || iBtn_D)) begin
                rBlock <= 1'b1;
            end else if (!iBtn_U && !iBtn_D) begin
                rBlock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_repeat_sched.sv
// tb/tb_btn_repeat_sched.sv - scoreboard bench for btn_repeat_sched against a tick-schedule model
module tb_btn_repeat_sched;

    localparam int T_HOLD      = 500;
    localparam int T_SLOW      = 200;
    localparam int T_FAST      = 50;
    localparam int T_AFTER     = 8;
    localparam int T_LAST_SLOW = T_HOLD + (T_AFTER - 1) * T_SLOW;

    logic iClk = 1'b0;
    logic iRst, iTick_1ms, iEn, iBtn_U, iBtn_D;
    logic oUp, oDown, oRepeat, oBusy;

    int total = 0;
    int bad   = 0;
    int upCount = 0;
    int dnCount = 0;

    bit expQ[$];
    bit mActive, mLock, mBlock, mDirUp;
    int mTicks;
    bit mU, mD, mAct, mOpp, mNb;

    btn_repeat_sched dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iTick_1ms (iTick_1ms),
        .iEn       (iEn),
        .iBtn_U    (iBtn_U),
        .iBtn_D    (iBtn_D),
        .oUp       (oUp),
        .oDown     (oDown),
        .oRepeat   (oRepeat),
        .oBusy     (oBusy)
    );

    always #5 iClk = ~iClk;

    // Tick index since press at which a repeat pulse is due
    function automatic bit isPulseTick(input int n);
        if (n == T_HOLD) return 1'b1;
        if (n > T_HOLD && n <= T_LAST_SLOW) return ((n - T_HOLD) % T_SLOW) == 0;
        if (n > T_LAST_SLOW) return ((n - T_LAST_SLOW) % T_FAST) == 0;
        return 1'b0;
    endfunction

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            mActive = 0; mLock = 0; mBlock = 0; mTicks = 0;
        end else begin
            mU = iBtn_U; mD = iBtn_D;
            mNb = mBlock;
            if (!iEn && (mU || mD)) mNb = 1;
            else if (!mU && !mD) mNb = 0;
            if (!iEn) begin
                mActive = 0; mLock = 0;
            end else if (mLock) begin
                if (!mU && !mD) mLock = 0;
            end else if (mActive) begin
                mAct = mDirUp ? mU : mD;
                mOpp = mDirUp ? mD : mU;
                if (!mAct) mActive = 0;
                else if (mOpp) begin mActive = 0; mLock = 1; end
                else if (iTick_1ms) begin
                    mTicks++;
                    if (isPulseTick(mTicks)) expQ.push_back(mDirUp);
                end
            end else if (!mBlock) begin
                if (mU ^ mD) begin
                    mActive = 1; mDirUp = mU; mTicks = 0;
                    expQ.push_back(mDirUp);
                end else if (mU && mD) mLock = 1;
            end
            mBlock = mNb;
        end
    end

    always @(negedge iClk) begin
        if (oUp) upCount++;
        if (oDown) dnCount++;
        if (oUp || oDown || expQ.size() != 0) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL pulse_unexpected t=%0t got up=%0b down=%0b required none", $time, oUp, oDown);
            end else begin
                bit eUp;
                eUp = expQ.pop_front();
                if (oUp !== eUp || oDown !== !eUp) begin
                    bad++;
                    $display("FAIL pulse t=%0t got up=%0b down=%0b required up=%0b down=%0b",
                             $time, oUp, oDown, eUp, !eUp);
                end
            end
        end
        total++;
        if (oBusy !== (mActive || mLock) || oRepeat !== mActive) begin
            bad++;
            $display("FAIL level t=%0t got busy=%0b repeat=%0b required busy=%0b repeat=%0b",
                     $time, oBusy, oRepeat, mActive || mLock, mActive);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit t);
        @(posedge iClk); #2;
        iTick_1ms = t;
    endtask

    task automatic setBtn(input bit en, input bit u, input bit d);
        @(posedge iClk); #2;
        iTick_1ms = 0; iEn = en; iBtn_U = u; iBtn_D = d;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(1, 3);
            repeat (gap - 1) cyc(1'b0);
            cyc(1'b1);
        end
    endtask

    initial begin
        int u0, d0;
        iRst = 1; iTick_1ms = 0; iEn = 1; iBtn_U = 0; iBtn_D = 0;
        repeat (3) @(posedge iClk);
        #1;
        chk("rst_up", oUp, 0);
        chk("rst_down", oDown, 0);
        chk("rst_repeat", oRepeat, 0);
        chk("rst_busy", oBusy, 0);
        #1 iRst = 0;
        repeat (3) cyc(1'b0);

        // single tap
        u0 = upCount; d0 = dnCount;
        setBtn(1, 1, 0); tickN(100); setBtn(1, 0, 0); repeat (3) cyc(1'b0);
        chk("tap_up_count", upCount - u0, 1);
        chk("tap_down_count", dnCount - d0, 0);
        chk("tap_busy_after", oBusy, 0);

        // long hold
        u0 = upCount; d0 = dnCount;
        setBtn(1, 0, 1); tickN(2010); setBtn(1, 0, 0); repeat (3) cyc(1'b0);
        chk("hold_down_count", dnCount - d0, 11);
        chk("hold_up_count", upCount - u0, 0);

        // release on the same cycle as the hold expiry
        u0 = upCount;
        setBtn(1, 1, 0); tickN(T_HOLD - 1);
        @(posedge iClk); #2; iTick_1ms = 1; iBtn_U = 0;
        repeat (3) cyc(1'b0);
        chk("relexp_up_count", upCount - u0, 1);
        chk("relexp_busy", oBusy, 0);

        // conflict
        u0 = upCount; d0 = dnCount;
        setBtn(1, 1, 0); tickN(600); setBtn(1, 1, 1); tickN(50);
        chk("conf_lock_busy", oBusy, 1);
        chk("conf_lock_repeat", oRepeat, 0);
        setBtn(1, 0, 1); tickN(20); setBtn(1, 0, 0); repeat (2) cyc(1'b0);
        chk("conf_up_count", upCount - u0, 2);
        chk("conf_down_count", dnCount - d0, 0);
        setBtn(1, 0, 1); repeat (2) cyc(1'b0);
        chk("conf_new_down", dnCount - d0, 1);
        setBtn(1, 0, 0); repeat (2) cyc(1'b0);

        // enable drop
        u0 = upCount;
        setBtn(1, 1, 0); tickN(300); setBtn(0, 1, 0); tickN(20);
        chk("endrop_busy", oBusy, 0);
        setBtn(1, 1, 0); tickN(20);
        chk("endrop_no_retrigger", upCount - u0, 1);
        setBtn(1, 0, 0); repeat (3) cyc(1'b0);
        setBtn(1, 1, 0); tickN(5); setBtn(1, 0, 0); repeat (2) cyc(1'b0);
        chk("endrop_repress", upCount - u0, 2);

        // async reset while in the slow phase
        u0 = upCount;
        setBtn(1, 1, 0); tickN(800);
        chk("slow_repeat_before_rst", oRepeat, 1);
        @(posedge iClk); #2; iTick_1ms = 0; iRst = 1;
        #1;
        chk("arst_up", oUp, 0);
        chk("arst_down", oDown, 0);
        chk("arst_repeat", oRepeat, 0);
        chk("arst_busy", oBusy, 0);
        @(posedge iClk); #2; iRst = 0;
        u0 = upCount;
        repeat (2) cyc(1'b0);
        chk("arst_new_press", upCount - u0, 1);
        setBtn(1, 0, 0); repeat (3) cyc(1'b0);

        // randomized episodes
        for (int ep = 0; ep < 20; ep++) begin
            int nseg;
            nseg = $urandom_range(1, 4);
            for (int s = 0; s < nseg; s++) begin
                int r;
                r = $urandom_range(0, 15);
                setBtn(r != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                tickN($urandom_range(0, 250));
            end
            setBtn(1, 0, 0); repeat (3) cyc(1'b0);
        end

        repeat (5) cyc(1'b0);
        chk("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_repeat_sched.md
Name: btn_repeat_sched

Overview:
- Auto-repeat scheduler between the debounced U/D buttons and the clock set-mode FSM.
- A press produces one immediate step pulse. Continued holding produces repeat pulses after a hold delay, at a slow rate and then a fast rate.
- Outputs feed the set FSM's up/down button inputs, so hour/min adjust accelerates while a button is held.

Parameters:
- P_HOLD_MS, 500: ticks from press to the first repeat pulse.
- P_SLOW_MS, 200: period in ticks between slow repeat pulses.
- P_FAST_MS, 50: period in ticks between fast repeat pulses.
- P_FAST_AFTER, 8: number of repeat pulses before switching to the fast rate.
- P_CNT_W, 10: tick counter width; must hold max(P_HOLD_MS, P_SLOW_MS, P_FAST_MS).

Ports:
- iClk  in  1  system clock.
- iRst  in  1  reset; asynchronous, active-high.
- iTick_1ms  in  1  one-iClk-cycle strobe every 1 ms.
- iEn  in  1  scheduling enable (set mode active).
- iBtn_U  in  1  debounced up-button level.
- iBtn_D  in  1  debounced down-button level.
- oUp  out  1  one-cycle up step pulse.
- oDown  out  1  one-cycle down step pulse.
- oRepeat  out  1  high while in HOLD, SLOW or FAST.
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock, asynchronous active-high reset. While iRst is high: state IDLE, counters 0, oUp = oDown = oRepeat = oBusy = 0.
- All outputs are registered. oUp and oDown are never high in the same cycle.
- Active direction register rDir is latched on the IDLE to HOLD transition.
- The "active button" below means iBtn_U when rDir = up, iBtn_D when rDir = down.
- IDLE:
  - iEn = 1 and exactly one button high: latch rDir, clear tick counter and repeat count, go HOLD. Matching pulse is high in the next cycle (1-cycle latency).
  - iEn = 1 and both buttons high: go LOCK, no pulse.
- HOLD:
  - Tick counter increments on each iTick_1ms.
  - On the tick that makes the count reach P_HOLD_MS: issue pulse (repeat #1), count cleared, repeat count = 1, go SLOW.
- SLOW:
  - Period P_SLOW_MS. Each expiry issues a pulse and increments the repeat count.
  - When the repeat count reaches P_FAST_AFTER, go FAST after that pulse.
  - Repeat count saturates and never wraps.
- FAST: period P_FAST_MS, pulse at each expiry, until exit.
- Exits from HOLD/SLOW/FAST:
  - Active button released: go IDLE, no pulse that cycle, even if a tick expires in the same cycle (release has priority).
  - Opposite button pressed while the active button is still held: go LOCK, no pulse.
- LOCK: no pulses. Return to IDLE only when both buttons are low.
- iEn low in any state: next cycle IDLE, any pending pulse suppressed. Held buttons are not re-detected until iEn = 1 again.
- Tick and button events in the same cycle: state exits take priority over period expiry.
- Counter compare uses equality to (period - 1) with iTick_1ms high. No counter overflow is possible within P_CNT_W.
- Reset mid-hold: immediate IDLE, no pulse. A still-held button after reset deassert counts as a new press (immediate pulse).

Decomposition:
- Shared package holds:
  - state encoding: IDLE, HOLD, SLOW, FAST, LOCK (3-bit);
  - direction constants DIR_UP / DIR_DN;
  - default timing constants.
- One sub-module: tick_interval_cnt.
  - Inputs: clear, tick, period.
  - Output: one-cycle expiry.
  - Width P_CNT_W.
- The FSM and output registers stay in btn_repeat_sched.

Test Plan:
- Single tap: iBtn_U high for 100 ticks -> exactly one oUp, one cycle after press; oDown never high; oBusy returns 0 after release.
- Long hold: iBtn_D held 2010 ticks (defaults) -> 11 oDown pulses.
  - Ticks 0, 500, 700, 900, 1100, 1300, 1500, 1700, 1900, 1950, 2000.
  - oRepeat high from tick 0 to release.
- Release at expiry: iBtn_U released in the same cycle as the tick-500 strobe -> no second pulse; state IDLE.
- Conflict: hold U to 600 ticks, then also press D -> pulses at 0 and 500 only.
  - LOCK entered; no pulses while either button is held.
  - After both low, a new D press gives an immediate oDown.
- Enable drop: hold U, deassert iEn at tick 300 -> IDLE next cycle, no further pulses. Re-assert iEn while U is held -> no pulse until U is released and pressed again.
- Async reset during SLOW at tick 800 -> all outputs 0 immediately, without waiting for an iClk edge. U still held after reset release -> one oUp one cycle later.
